motor_ramp_ctrl: RTL

//  Sequencer between the up/down buttons and the PWM stage of the motor path.
//  - Holds a target speed level set by button presses.
//  - Slews the PWM control value (o_cv) toward the target at a fixed tick rate.
//  - On a direction change: ramps to 0, inserts an H-bridge dead time, then re-ramps.
//  - Exports BCD digits of the target for the two seven-segment decoders.

---
 rtl/motor_pkg.sv | 16 +
 rtl/btn_sync_edge.sv | 21 ++
 rtl/motor_ramp_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/motor_pkg.sv
// rtl/motor_pkg.sv - shared state encoding, default widths and direction constants for the motor path
package motor_pkg;

  localparam int CV_W_DEF = 4;

  typedef logic [1:0] state_t;

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_RAMP = 2'd1;
  localparam logic [1:0] S_STOP = 2'd2;
  localparam logic [1:0] S_DEAD = 2'd3;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

endpackage

// File: rtl/btn_sync_edge.sv
// rtl/btn_sync_edge.sv - two-flop synchroniser with a one-cycle rising-edge pulse
module btn_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise
);

  // sh[1] is the synchronised level; sh[2] holds its previous value for edge detection
  logic [2:0] sh;

  always_ff @(posedge clk) begin
    if (reset) sh <= '0;
    else       sh <= {sh[1:0], din};
  end

  assign level = sh[1];
  assign rise  = sh[1] & ~sh[2];

endmodule

// File: rtl/motor_ramp_ctrl.sv
// rtl/motor_ramp_ctrl.sv - button-set target, ticked slew of o_cv, reversal via stop and dead time
// Optional MOTOR_CTRL_BRAKE_EN: both bridge inputs high when idle in S_RUN at zero.
module motor_ramp_ctrl
  import motor_pkg::*;
#(
  parameter int CV_W       = CV_W_DEF,
  parameter int CV_MAX     = 15,
  parameter int RAMP_DIV   = 4,
  parameter int DEAD_TICKS = 8
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_tick,
  input  logic            i_bu,
  input  logic            i_bd,
  input  logic            i_dir,
  output logic [CV_W-1:0] o_cv,
  output logic [CV_W-1:0] o_target,
  output logic [3:0]      o_left_digit,
  output logic [3:0]      o_right_digit,
  output logic            o_in1,
  output logic            o_in2,
  output logic            o_busy
);

  localparam int CNT_MAX = (RAMP_DIV > DEAD_TICKS) ? RAMP_DIV : DEAD_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] RAMP_LAST = CNT_W'(RAMP_DIV - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_TICKS - 1);
  localparam logic [CV_W-1:0]  TGT_MAX   = CV_W'(CV_MAX);

`ifdef MOTOR_CTRL_BRAKE_EN
  localparam logic BRAKE = 1'b1;
`else
  localparam logic BRAKE = 1'b0;
`endif

  logic bu_rise, bd_rise, bu_level, bd_level;
  logic dir_meta, dir_s, dir_app, dir_n;
  state_t state, act, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CV_W-1:0] cv_n, tgt_n, goal, tens, ones;
  logic br1, br2;

  btn_sync_edge u_bu (.clk(i_clk), .reset(i_reset), .din(i_bu), .level(bu_level), .rise(bu_rise));
  btn_sync_edge u_bd (.clk(i_clk), .reset(i_reset), .din(i_bd), .level(bd_level), .rise(bd_rise));

  always_comb begin
    tgt_n = o_target;
    if (bu_rise && !bd_rise && o_target < TGT_MAX)  tgt_n = o_target + 1'b1;
    else if (bd_rise && !bu_rise && o_target != '0) tgt_n = o_target - 1'b1;
  end

  always_comb begin
    act   = state;
    cnt_n = cnt;
    cv_n  = o_cv;
    dir_n = dir_app;
    goal  = o_target;
    case (state)
      S_RUN:  if (dir_s != dir_app)   act = (o_cv != '0) ? S_STOP : S_DEAD;
              else if (o_cv != o_target) act = S_RAMP;
      S_RAMP: if (dir_s != dir_app) act = S_STOP;
              else if (o_cv == o_target) begin act = S_RUN; cnt_n = '0; end
      S_STOP: if (o_cv == '0) begin act = S_DEAD; cnt_n = '0; end
      default: ;
    endcase
    state_n = act;
    // A tick on the cycle of a transition is spent in the state being entered
    if (i_tick) begin
      case (act)
        S_RAMP, S_STOP: begin
          goal = (act == S_STOP) ? '0 : o_target;
          if (cnt_n == RAMP_LAST) begin
            cnt_n = '0;
            if (o_cv < goal)      cv_n = o_cv + 1'b1;
            else if (o_cv > goal) cv_n = o_cv - 1'b1;
          end else begin
            cnt_n = cnt_n + 1'b1;
          end
        end
        S_DEAD: begin
          if (cnt_n == DEAD_LAST) begin
            cnt_n   = '0;
            dir_n   = dir_s;
            state_n = (o_target == '0) ? S_RUN : S_RAMP;
          end else begin
            cnt_n = cnt_n + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Bridge drive is derived from next-state values so it registers alongside o_cv
  always_comb begin
    br1 = 1'b0;
    br2 = 1'b0;
    if (state_n != S_DEAD && cv_n != '0) begin
      br1 = ~dir_n;
      br2 = dir_n;
    end else if (BRAKE && state_n == S_RUN && cv_n == '0 && tgt_n == '0) begin
      br1 = 1'b1;
      br2 = 1'b1;
    end
  end

  assign tens = o_target / CV_W'(10);
  assign ones = o_target % CV_W'(10);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= S_RUN;
      cnt           <= '0;
      o_cv          <= '0;
      o_target      <= '0;
      dir_meta      <= DIR_FWD;
      dir_s         <= DIR_FWD;
      dir_app       <= DIR_FWD;
      o_in1         <= 1'b0;
      o_in2         <= 1'b0;
      o_busy        <= 1'b0;
      o_left_digit  <= '0;
      o_right_digit <= '0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      o_cv          <= cv_n;
      o_target      <= tgt_n;
      dir_meta      <= i_dir;
      dir_s         <= dir_meta;
      dir_app       <= dir_n;
      o_in1         <= br1;
      o_in2         <= br2;
      o_busy        <= (state_n != S_RUN);
      o_left_digit  <= 4'(tens);
      o_right_digit <= 4'(ones);
    end
  end

endmodule
